nibble_link_tx: RTL and testbench

//  Serial transmitter: sends a frame over a single wire carrying NUM_NIBBLES 4-bit words.

---
 rtl/nibble_link_tx.sv | 133 +++++++++++++
 tb/tb_nibble_link_tx.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_link_tx.sv
// Nibble link serial transmitter: start bit, DW data bits LSB first, optional even
// parity bit, stop bit. One packed word per frame is accepted over valid/ready.
module nibble_link_tx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int NUM_NIBBLES  = 3,
  parameter int PARITY_EN    = 1,
  localparam int DW          = 4 * NUM_NIBBLES
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          tx_out,
  output logic          busy,
  output logic          done
);

  // Handshake: a word transfers on a rising edge where in_valid && in_ready.
  // in_ready is a registered copy of "state is IDLE"; in_valid never reaches an output combinationally.

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (DW > 1) ? $clog2(DW) : 1;
  localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DW - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t        state;
  logic [CW-1:0] cyc_cnt;
  logic [BW-1:0] bit_cnt;
  logic [DW-1:0] shreg;
  logic          par;
  logic          bit_end;

  assign bit_end = (cyc_cnt == CYC_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      cyc_cnt  <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      par      <= 1'b0;
      tx_out   <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      in_ready <= 1'b1;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            shreg    <= in_data;
            par      <= ^in_data;
            cyc_cnt  <= '0;
            bit_cnt  <= '0;
            tx_out   <= 1'b0;
            busy     <= 1'b1;
            in_ready <= 1'b0;
            state    <= S_START;
          end
        end
        S_START: begin
          if (bit_end) begin
            cyc_cnt <= '0;
            tx_out  <= shreg[0];
            shreg   <= shreg >> 1;
            state   <= S_DATA;
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            cyc_cnt <= '0;
            if (bit_cnt == BIT_LAST) begin
              if (PARITY_EN != 0) begin
                tx_out <= par;
                state  <= S_PARITY;
              end else begin
                tx_out <= 1'b1;
                state  <= S_STOP;
              end
            end else begin
              // tx_out is registered, so the next bit is loaded as the current one ends.
              bit_cnt <= bit_cnt + 1'b1;
              tx_out  <= shreg[0];
              shreg   <= shreg >> 1;
            end
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end
        S_PARITY: begin
          if (bit_end) begin
            cyc_cnt <= '0;
            tx_out  <= 1'b1;
            state   <= S_STOP;
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (bit_end) begin
            cyc_cnt  <= '0;
            tx_out   <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b1;
            in_ready <= 1'b1;
            state    <= S_IDLE;
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end
        default: begin
          cyc_cnt  <= '0;
          tx_out   <= 1'b1;
          busy     <= 1'b0;
          in_ready <= 1'b1;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_link_tx.sv
// Bench for nibble_link_tx: default instance (4 clk/bit, parity) and a
// 1 clk/bit no-parity instance, both checked against a per-cycle line model.
module tb_nibble_link_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [11:0] in_data = '0;
  logic        in_ready, tx_out, busy, done;

  logic        in_valid1 = 1'b0;
  logic [11:0] in_data1 = '0;
  logic        in_ready1, tx_out1, busy1, done1;

  int checks = 0;
  int errors = 0;

  logic [0:0] exp_q[$];

  always #5 clk = ~clk;

  nibble_link_tx #(.CLKS_PER_BIT(4), .NUM_NIBBLES(3), .PARITY_EN(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .tx_out(tx_out), .busy(busy), .done(done)
  );

  nibble_link_tx #(.CLKS_PER_BIT(1), .NUM_NIBBLES(3), .PARITY_EN(0)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_data(in_data1), .tx_out(tx_out1), .busy(busy1), .done(done1)
  );

  // Expected line level for every cycle of a frame, starting with the first START cycle.
  function automatic void build_exp(input logic [11:0] d, input int cpb, input int par_en);
    int nbits;
    logic lvl;
    exp_q.delete();
    nbits = 2 + 12 + par_en;
    for (int b = 0; b < nbits; b++) begin
      if (b == 0) lvl = 1'b0;
      else if (b <= 12) lvl = d[b-1];
      else if (par_en != 0 && b == 13) lvl = ^d;
      else lvl = 1'b1;
      for (int c = 0; c < cpb; c++) exp_q.push_back(lvl);
    end
  endfunction

  task automatic start_frame0(input logic [11:0] d);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL start_ready: in_ready=%b required 1", in_ready);
    end
    in_valid = 1'b1;
    in_data  = d;
    build_exp(d, 4, 1);
    @(posedge clk);
  endtask

  // mode 0: drop valid after accept; 1: hammer valid with FFF while busy; 2: keep valid, switch to nxt
  task automatic run_frame0(input string name, input int mode, input logic [11:0] nxt);
    int   k;
    int   flen;
    logic lvl;
    k = 0;
    flen = exp_q.size();
    while (exp_q.size() > 0) begin
      lvl = exp_q.pop_front();
      @(negedge clk);
      if (mode == 0 && k == 0) in_valid = 1'b0;
      if (mode == 1) begin
        in_data  = 12'hFFF;
        in_valid = (k < flen - 1);
      end
      if (mode == 2 && k == 0) in_data = nxt;
      checks++;
      if ({tx_out, busy, in_ready, done} !== {lvl, 3'b100}) begin
        errors++;
        $display("FAIL %s cyc %0d: tx/busy/rdy/done=%b%b%b%b required %b100",
                 name, k, tx_out, busy, in_ready, done, lvl);
      end
      k++;
    end
    @(negedge clk);
    checks++;
    if ({tx_out, busy, in_ready, done} !== 4'b1011) begin
      errors++;
      $display("FAIL %s done_cycle: tx/busy/rdy/done=%b%b%b%b required 1011",
               name, tx_out, busy, in_ready, done);
    end
  endtask

  task automatic check_idle0(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checks++;
      if ({tx_out, busy, in_ready, done} !== 4'b1010) begin
        errors++;
        $display("FAIL %s idle %0d: tx/busy/rdy/done=%b%b%b%b required 1010",
                 name, i, tx_out, busy, in_ready, done);
      end
    end
  endtask

  task automatic test_reset();
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checks++;
    if ({tx_out, in_ready, busy, done} !== 4'b1100) begin
      errors++;
      $display("FAIL reset: tx/rdy/busy/done=%b%b%b%b required 1100", tx_out, in_ready, busy, done);
    end
    checks++;
    if ({tx_out1, in_ready1, busy1, done1} !== 4'b1100) begin
      errors++;
      $display("FAIL reset_cpb1: tx/rdy/busy/done=%b%b%b%b required 1100",
               tx_out1, in_ready1, busy1, done1);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    check_idle0("post_reset", 3);
  endtask

  task automatic test_a5c();
    start_frame0(12'hA5C);
    run_frame0("a5c", 0, 12'h000);
    check_idle0("a5c_after", 2);
  endtask

  task automatic test_random();
    logic [11:0] d;
    repeat (8) begin
      d = 12'($urandom_range(0, 4095));
      start_frame0(d);
      run_frame0("random", 0, 12'h000);
      check_idle0("random_gap", $urandom_range(0, 2));
    end
  endtask

  task automatic test_back_to_back();
    start_frame0(12'h001);
    run_frame0("b2b_first", 2, 12'h800);
    build_exp(12'h800, 4, 1);
    run_frame0("b2b_second", 0, 12'h000);
    check_idle0("b2b_after", 2);
  endtask

  task automatic test_busy_ignore();
    start_frame0(12'($urandom_range(0, 4094)));
    run_frame0("busy_ignore", 1, 12'h000);
    check_idle0("busy_no_extra", 6);
  endtask

  task automatic test_reset_mid();
    logic lvl;
    start_frame0(12'($urandom_range(0, 4095)));
    for (int k = 0; k < 26; k++) begin
      lvl = exp_q.pop_front();
      @(negedge clk);
      if (k == 0) in_valid = 1'b0;
      checks++;
      if ({tx_out, busy} !== {lvl, 1'b1}) begin
        errors++;
        $display("FAIL pre_abort cyc %0d: tx/busy=%b%b required %b1", k, tx_out, busy, lvl);
      end
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({tx_out, busy, in_ready, done} !== 4'b1010) begin
      errors++;
      $display("FAIL abort: tx/busy/rdy/done=%b%b%b%b required 1010", tx_out, busy, in_ready, done);
    end
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    check_idle0("abort_no_done", 5);
    start_frame0(12'h123);
    run_frame0("after_abort", 0, 12'h000);
  endtask

  task automatic test_cpb1(input logic [11:0] d);
    int   k;
    logic lvl;
    @(negedge clk);
    checks++;
    if (in_ready1 !== 1'b1) begin
      errors++;
      $display("FAIL cpb1_ready: in_ready=%b required 1", in_ready1);
    end
    in_valid1 = 1'b1;
    in_data1  = d;
    build_exp(d, 1, 0);
    @(posedge clk);
    k = 0;
    while (exp_q.size() > 0) begin
      lvl = exp_q.pop_front();
      @(negedge clk);
      if (k == 0) in_valid1 = 1'b0;
      checks++;
      if ({tx_out1, busy1, in_ready1, done1} !== {lvl, 3'b100}) begin
        errors++;
        $display("FAIL cpb1 cyc %0d: tx/busy/rdy/done=%b%b%b%b required %b100",
                 k, tx_out1, busy1, in_ready1, done1, lvl);
      end
      k++;
    end
    @(negedge clk);
    checks++;
    if ({tx_out1, busy1, in_ready1, done1} !== 4'b1011) begin
      errors++;
      $display("FAIL cpb1 done_cycle: tx/busy/rdy/done=%b%b%b%b required 1011",
               tx_out1, busy1, in_ready1, done1);
    end
  endtask

  initial begin
    test_reset();
    test_a5c();
    test_random();
    test_back_to_back();
    test_busy_ignore();
    test_reset_mid();
    test_cpb1(12'hFFF);
    test_cpb1(12'($urandom_range(0, 4095)));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
